// File: rtl/sim_to_seq_dbuf_lanes_reg.sv
// Parallel-to-serial converter with a shadow buffer for back-to-back blocks.
// A SHIFT_LEN-word block is emitted LANES words per beat, one beat per
// D-cycle window; valid marks the last cycle of each window. An optional
// bypass shows beat 0 in the load cycle itself when the converter is idle.
module sim_to_seq_dbuf_lanes_reg #(
   parameter int DIRECTION    = 1,
   parameter int SHIFT_LEN    = 4,
   parameter int BIT_WIDTH    = 8,
   parameter int LANES        = 1,
   parameter int CLK_DISTANCE = 1,
   parameter int PASSING_FIR  = 0
) (
   input  logic                           clk,
   input  logic                           in_ctr_Srst,
   input  logic                           in_ctr_en,
   input  logic                           in_ctr_load,
   input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
   output logic [BIT_WIDTH*LANES-1:0]     out,
   output logic                           out_ctr_valid,
   output logic                           out_ctr_last,
   output logic                           out_ctr_busy,
   output logic                           out_ctr_load_ready
);

   localparam int BEATS  = SHIFT_LEN / LANES;
   localparam int D      = (CLK_DISTANCE < 1) ? 1 : CLK_DISTANCE;
   localparam int BLK_W  = BIT_WIDTH * SHIFT_LEN;
   localparam int OUT_W  = BIT_WIDTH * LANES;
   localparam int BCNT_W = $clog2(BEATS) + 1;
   localparam int CCNT_W = $clog2(D) + 1;
   localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEATS - 1);
   localparam logic [CCNT_W-1:0] CYC_LAST  = CCNT_W'(D - 1);
   localparam bit BYPASS   = (PASSING_FIR != 0);
   localparam bit ONE_CYC  = (D == 1);
   localparam bit ONE_BEAT = (BEATS == 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [BLK_W-1:0]    act_q, act_d;
   logic [BLK_W-1:0]    shd_q, shd_d;
   logic                shd_full_q, shd_full_d;
   logic [BCNT_W-1:0]   beat_q, beat_d;
   logic [CCNT_W-1:0]   cyc_q, cyc_d;
   logic                ready_q, ready_d;

   logic                load_acc_s;
   logic                win_end_s;
   logic                blk_end_s;
   logic                bypass_s;

   // Beat k of a block; DIRECTION selects whether beat 0 is the low or high slice.
   function automatic logic [OUT_W-1:0] beat_slice(input logic [BLK_W-1:0] blk, input int k);
      int               idx;
      logic [BLK_W-1:0] shifted;
      if (DIRECTION != 0) begin
         idx = k;
      end else begin
         idx = BEATS - 1 - k;
      end
      shifted = blk >> (idx * OUT_W);
      return shifted[OUT_W-1:0];
   endfunction

   // Load acceptance and window/block boundary detection.
   always_comb begin
      load_acc_s = in_ctr_en && ready_q && in_ctr_load && !in_ctr_Srst;
      win_end_s  = (state_q == ST_SHIFT) && (cyc_q == CYC_LAST);
      blk_end_s  = win_end_s && (beat_q == BEAT_LAST);
      bypass_s   = BYPASS && (state_q == ST_IDLE) && load_acc_s;
   end

   // Output beat selection and capture strobes (bypass path shows beat 0 of in).
   always_comb begin
      out           = '0;
      out_ctr_valid = 1'b0;
      out_ctr_last  = 1'b0;
      if (state_q == ST_SHIFT) begin
         out           = beat_slice(act_q, int'(beat_q));
         out_ctr_valid = in_ctr_en && !in_ctr_Srst && win_end_s;
         out_ctr_last  = in_ctr_en && !in_ctr_Srst && blk_end_s;
      end else if (bypass_s) begin
         out           = beat_slice(in, 32'sd0);
         out_ctr_valid = ONE_CYC;
         out_ctr_last  = ONE_CYC && ONE_BEAT;
      end else begin
         out           = '0;
         out_ctr_valid = 1'b0;
         out_ctr_last  = 1'b0;
      end
      out_ctr_busy       = (state_q == ST_SHIFT);
      out_ctr_load_ready = ready_q;
   end

   // Next-state logic: counters, active/shadow buffers and IDLE/SHIFT state.
   always_comb begin
      state_d    = state_q;
      act_d      = act_q;
      shd_d      = shd_q;
      shd_full_d = shd_full_q;
      beat_d     = beat_q;
      cyc_d      = cyc_q;
      case (state_q)
         ST_IDLE: begin
            if (load_acc_s) begin
               act_d   = in;
               state_d = ST_SHIFT;
               beat_d  = '0;
               cyc_d   = '0;
               // The load cycle counts as the first cycle of beat 0.
               if (BYPASS) begin
                  if (ONE_CYC) begin
                     if (ONE_BEAT) begin
                        state_d = ST_IDLE;
                     end else begin
                        beat_d = BCNT_W'(1);
                     end
                  end else begin
                     cyc_d = CCNT_W'(1);
                  end
               end else begin
                  cyc_d = '0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (in_ctr_en) begin
               if (win_end_s) begin
                  cyc_d = '0;
                  if (blk_end_s) begin
                     beat_d = '0;
                  end else begin
                     beat_d = beat_q + BCNT_W'(1);
                  end
               end else begin
                  cyc_d = cyc_q + CCNT_W'(1);
               end
               if (blk_end_s) begin
                  if (shd_full_q) begin
                     act_d      = shd_q;
                     shd_full_d = 1'b0;
                  end else if (load_acc_s) begin
                     act_d = in;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (load_acc_s) begin
                  shd_d      = in;
                  shd_full_d = 1'b1;
               end else begin
                  shd_full_d = shd_full_q;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = ~shd_full_d;
   end

   // State registers with synchronous reset that aborts any block in flight.
   always_ff @(posedge clk) begin
      if (in_ctr_Srst) begin
         state_q    <= ST_IDLE;
         act_q      <= '0;
         shd_q      <= '0;
         shd_full_q <= 1'b0;
         beat_q     <= '0;
         cyc_q      <= '0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         act_q      <= act_d;
         shd_q      <= shd_d;
         shd_full_q <= shd_full_d;
         beat_q     <= beat_d;
         cyc_q      <= cyc_d;
         ready_q    <= ready_d;
      end
   end

endmodule
